// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM encoding
// and the legality rule used at request accept.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    LD_ADDR,
    LD_DATA,
    ST_WR,
    RMW_ADDR,
    RMW_DATA,
    RMW_WR,
    ERR
  } mem_state_e;

  // Latched request; the word address lives in mem_addr, the data in mem_din.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } mem_req_t;

  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic ill, mis;
    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
          (we && (f3 == F3_BU || f3 == F3_HU));
    mis = ((f3 == F3_H || f3 == F3_HU) && off[0]) ||
          ((f3 == F3_W) && (off != 2'b00));
    return ill || mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and
// merges a byte or halfword of store data into a memory word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word[{off, 3'b000} +: 8];
    h       = off[1] ? word[31:16] : word[15:0];
    ld_data = word;
    case (funct3)
      F3_B:    ld_data = {{24{b[7]}}, b};
      F3_BU:   ld_data = {24'h0, b};
      F3_H:    ld_data = {{16{h[15]}}, h};
      F3_HU:   ld_data = {16'h0, h};
      default: ld_data = word;
    endcase

    // Only SB/SH reach the merge path, so funct3[1:0] picks byte vs halfword.
    merged = word;
    if (funct3[1:0] == 2'b00)
      merged[{off, 3'b000} +: 8] = wdata[7:0];
    else if (off[1])
      merged[31:16] = wdata;
    else
      merged[15:0] = wdata;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a valid/ready request port and a synchronous
// word-wide data memory; sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  mem_state_e  state;
  mem_req_t    req_q;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);

  // mem_din doubles as the latched store data until the merge overwrites it.
  mem_lane_align u_align (
    .word    (mem_dout),
    .off     (req_q.off),
    .funct3  (req_q.funct3),
    .wdata   (mem_din[15:0]),
    .ld_data (ld_data),
    .merged  (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q    <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
            mem_addr <= {req_addr[ADDRW-1:2], 2'b00};
            mem_din  <= req_wdata;
            if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
              state <= ERR;
            end else if (!req_we) begin
              state <= LD_ADDR;
            end else if (req_funct3 == F3_W) begin
              state  <= ST_WR;
              mem_we <= 1'b1;
            end else begin
              state <= RMW_ADDR;
            end
          end
        end
        LD_ADDR: state <= LD_DATA;
        LD_DATA: begin
          resp_valid <= 1'b1;
          resp_rdata <= req_q.we ? 32'h0 : ld_data;
          state      <= IDLE;
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_ADDR: state <= RMW_DATA;
        RMW_DATA: begin
          mem_din <= merged;
          mem_we  <= 1'b1;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench: byte-array reference model of memory plus latency/error
// rules, with a synchronous word RAM behind the DUT.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_din, mem_dout;
  logic [7:0]  mem_addr;

  logic [31:0] mem_arr [0:63];
  logic [5:0]  addr_q;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  logic [7:0]  ref_bytes [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDRW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Synchronous RAM: registered address, registered write.
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_idx] <= pl_data;
    else if (mem_we) mem_arr[mem_addr[7:2]] <= mem_din;
    addr_q <= mem_addr[7:2];
  end
  assign mem_dout = mem_arr[addr_q];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    logic [7:0] base;
    base = {a[7:2], 2'b00};
    return {ref_bytes[base + 8'd3], ref_bytes[base + 8'd2],
            ref_bytes[base + 8'd1], ref_bytes[base]};
  endfunction

  // Reference: waits from the accept edge, checks latency, data, error and
  // number of write pulses, then applies a good store to the byte model.
  task automatic expect_resp(input logic we, input logic [2:0] f3,
                             input logic [7:0] a, input logic [31:0] wd);
    logic        bad;
    int          lat, got_lat, wcnt, nbytes;
    logic [31:0] exp_d, got_d;
    logic        got_e;
    logic [7:0]  b;
    logic [15:0] h;
    bad = (f3 == 3 || f3 >= 6) || (we && f3 >= 4) ||
          ((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0);
    lat = bad ? 2 : (!we ? 3 : (f3 == 2 ? 2 : 4));
    b = ref_bytes[a];
    h = {ref_bytes[a + 8'd1], ref_bytes[a]};
    exp_d = 32'h0;
    if (!bad && !we) begin
      case (f3)
        3'd0: exp_d = 32'($signed(b));
        3'd4: exp_d = 32'(b);
        3'd1: exp_d = 32'($signed(h));
        3'd5: exp_d = 32'(h);
        default: exp_d = rd_word(a);
      endcase
    end
    got_lat = 0; wcnt = 0; got_d = 32'hx; got_e = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_we) begin
        wcnt++;
        chk("waddr_lo", 32'(mem_addr[1:0]), 32'd0);
      end
      if (resp_valid) begin
        got_lat = k; got_d = resp_rdata; got_e = resp_err;
        break;
      end
    end
    chk("latency", got_lat, lat);
    chk("err", 32'(got_e), 32'(bad));
    chk("rdata", got_d, exp_d);
    chk("we_pulses", wcnt, (!bad && we) ? 1 : 0);
    if (!bad && we) begin
      nbytes = (f3 == 0) ? 1 : (f3 == 1 ? 2 : 4);
      for (int i = 0; i < nbytes; i++) ref_bytes[a + 8'(i)] = wd[8*i +: 8];
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [7:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk("ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    expect_resp(we, f3, a, wd);
  endtask

  initial begin
    int wcnt, rcnt;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 8'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;

    // Preload memory and model while in reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = $urandom;
      for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = pl_data[8*j +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Word store/load, sub-word stores and lane extraction.
    do_req(1'b1, 3'd2, 8'h10, 32'h12345678);
    do_req(1'b0, 3'd2, 8'h10, 32'h0);
    do_req(1'b1, 3'd0, 8'h11, 32'hDEADBEAB);
    do_req(1'b0, 3'd2, 8'h10, 32'h0);
    chk("sb_merge_word", rd_word(8'h10), 32'h1234AB78);
    do_req(1'b0, 3'd0, 8'h11, 32'h0);
    do_req(1'b0, 3'd4, 8'h11, 32'h0);
    do_req(1'b1, 3'd1, 8'h12, 32'h55558001);
    do_req(1'b0, 3'd1, 8'h12, 32'h0);
    do_req(1'b0, 3'd5, 8'h12, 32'h0);
    do_req(1'b0, 3'd2, 8'h10, 32'h0);
    chk("sh_merge_word", rd_word(8'h10), 32'h8001AB78);

    // Misaligned and illegal requests.
    do_req(1'b0, 3'd2, 8'h13, 32'h0);
    do_req(1'b1, 3'd1, 8'h11, 32'hFFFF);
    do_req(1'b0, 3'd3, 8'h10, 32'h0);
    do_req(1'b1, 3'd4, 8'h10, 32'h0);

    // Reset during the read phase of an SB: nothing may be written or answered.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 8'h10; req_wdata = 32'h000000EE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wcnt = 0; rcnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_we) wcnt++;
      if (resp_valid) rcnt++;
      if (k == 2) rst = 1'b1;
      if (k == 3) chk("rst_mid_ready", 32'(req_ready), 32'd1);
      if (k == 2) begin
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    chk("rst_mid_we", wcnt, 0);
    chk("rst_mid_resp", rcnt, 0);
    do_req(1'b0, 3'd2, 8'h10, 32'h0);

    // Back-to-back SW then LW with req_valid held high.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 8'h20; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    expect_resp(1'b1, 3'd2, 8'h20, 32'hCAFEF00D);
    chk("b2b_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    expect_resp(1'b0, 3'd2, 8'h20, 32'h0);
    chk("b2b_word", rd_word(8'h20), 32'hCAFEF00D);

    // Random traffic, biased towards aligned addresses.
    for (int n = 0; n < 80; n++) begin
      logic [7:0] a;
      a = 8'($urandom);
      if ($urandom_range(0, 2) != 0) a = a & 8'hFC;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Whole-memory comparison against the byte model.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem_arr[i], rd_word(8'(4*i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDRW, default 32: width of req_addr and mem_addr.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted on an edge where req_valid and req_ready are both 1.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV32 width code. 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-008 SHALL have port req_addr, input, ADDRW: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse; no backpressure.
REQ-011 SHALL have port resp_rdata, output, 32: load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1: misaligned or illegal request; qualified by resp_valid.
REQ-013 SHALL have port mem_we, output, 1: word write enable to data memory.
REQ-014 SHALL have port mem_addr, output, ADDRW: byte address to data memory; low 2 bits forced 0.
REQ-015 SHALL have port mem_din, output, 32: write word.
REQ-016 SHALL have port mem_dout, input, 32: read word; valid in the cycle after mem_addr is presented.

Function
REQ-017 SHALL drive mem_we, mem_addr and mem_din from registers only; no combinational path from req_* to mem_*.
REQ-018 SHALL implement FSM states IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_ADDR, RMW_DATA, RMW_WR and ERR.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL, on accept, latch req_we, req_funct3, req_addr and req_wdata.
REQ-021 SHALL, on accept, transition as follows: illegal or misaligned to ERR; load to LD_ADDR; SW to ST_WR; SB or SH to RMW_ADDR.
REQ-022 SHALL treat as illegal: funct3 3, 6 or 7; any store with funct3 4 or 5.
REQ-023 SHALL treat as misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
REQ-024 SHALL sequence loads LD_ADDR -> LD_DATA -> IDLE, with mem_we=0 throughout.
REQ-025 SHALL, for a load, capture the lane of mem_dout selected by addr[1:0] at the LD_DATA exit edge, sign-extending for B/H and zero-extending for BU/HU.
REQ-026 SHALL make load resp_valid high exactly 3 cycles after the accept edge.
REQ-027 SHALL, in ST_WR, drive mem_we=1 and mem_din=req_wdata for exactly one cycle, then return to IDLE; resp_valid is high 2 cycles after accept.
REQ-028 SHALL sequence sub-word stores RMW_ADDR -> RMW_DATA -> RMW_WR -> IDLE.
REQ-029 SHALL, in RMW_DATA, register the merged word: mem_dout with the addressed byte or halfword replaced by the low bits of wdata.
REQ-030 SHALL, in RMW_WR, drive mem_we=1 with the merged word for one cycle; resp_valid is high 4 cycles after accept.
REQ-031 SHALL, in ERR, hold mem_we=0 for one cycle, then return to IDLE, with resp_err=1 and resp_rdata=0 and resp_valid high 2 cycles after accept.
REQ-032 SHALL guarantee that any request accepted after a store completes observes that store's data; the memory commits one edge after the mem_we cycle, and this ordering covers it.
REQ-033 SHALL assert mem_we only in ST_WR and RMW_WR.

Reset
REQ-034 SHALL, when rst=1 at an edge in any state, enter IDLE and clear mem_we, mem_addr, mem_din, resp_valid, resp_err and resp_rdata to 0.
REQ-035 SHALL drop any in-flight request on reset with no response; a write whose mem_we cycle preceded the reset edge can still commit in memory.
REQ-036 SHALL ignore req_valid in the cycle rst=1; req_ready is high from the first cycle after reset.

Structure
REQ-037 SHALL place the funct3 codes and the FSM state encoding in shared package mem_pkg.
REQ-038 SHALL implement lane extract/extend and lane merge as combinational sub-module mem_lane_align.

Verification
REQ-039 SHALL cover: SW 0x12345678 @0x10, then LW @0x10 -> resp_rdata=0x12345678; one mem_we pulse; resp pulses at +2 and +3 cycles.
REQ-040 SHALL cover: after REQ-039, SB 0x...AB @0x11 then LW @0x10 -> 0x1234AB78; LB @0x11 -> 0xFFFFFFAB; LBU @0x11 -> 0x000000AB.
REQ-041 SHALL cover: SH 0x8001 @0x12 then LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x10 -> 0x8001AB78.
REQ-042 SHALL cover: LW @0x13, SH @0x11 and funct3=3 -> each resp_err=1, rdata=0, mem_we never 1, resp at +2.
REQ-043 SHALL cover: rst=1 during RMW_DATA of SB -> no mem_we, no resp_valid; req_ready=1 the next cycle; memory word unchanged.
REQ-044 SHALL cover: back-to-back SW @0x20 then LW @0x20 with req_valid held high -> LW returns the new data; memory model uses registered address and registered write, as the data memory does.
